// File: rtl/fir_pkg.sv
// Shared constants and types for the pulse-oximetry FIR filter family.
//   NTAPS/DW/CW/AW : filter length, sample, coefficient and accumulator widths
//   H              : unique half of the symmetric coefficient set, H[0] = outermost tap
//   state_t        : scheduler FSM states
//   CH_RED/CH_IR   : channel tags carried on out_ch
package fir_pkg;

    localparam int NTAPS = 22;
    localparam int DW    = 8;
    localparam int CW    = 9;
    localparam int AW    = 20;
    localparam int TW    = $clog2(NTAPS);
    localparam int HW    = $clog2(NTAPS / 2);

    // Packed so H[0] is the rightmost entry (2), H[10] the centre tap (128).
    localparam logic [NTAPS/2-1:0][CW-1:0] H = {
        9'd128, 9'd122, 9'd111, 9'd95, 9'd78, 9'd60,
        9'd43,  9'd28,  9'd16,  9'd10, 9'd2
    };

    typedef enum logic [1:0] {IDLE, SHIFT, MAC, DONE} state_t;

    localparam logic CH_RED = 1'b0;
    localparam logic CH_IR  = 1'b1;

endpackage

// File: rtl/fir_coef_rom.sv
// Folded coefficient lookup for a symmetric FIR.
//   tap  : tap index 0..NTAPS-1
//   coef : H[tap] for the first half, H[NTAPS-1-tap] for the mirrored half
module fir_coef_rom
    import fir_pkg::*;
(
    input  logic [TW-1:0] tap,
    output logic [CW-1:0] coef
);

    localparam logic [TW-1:0] LAST = TW'(NTAPS - 1);
    localparam logic [TW-1:0] HALF = TW'(NTAPS / 2);

    logic [HW-1:0] idx;

    always_comb begin
        idx  = HW'((tap < HALF) ? tap : LAST - tap);
        coef = H[idx];
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Two-channel (red / IR) symmetric FIR sharing one 9x8 MAC.
//   CLK_Filter, rst_n       : clock, asynchronous active-high reset
//   red_valid/red_sample    : red ADC strobe and sample
//   ir_valid/ir_sample      : IR ADC strobe and sample
//   out_data/out_valid/out_ch : filtered result, one-cycle valid, channel tag
//   busy                    : scheduler is servicing a sample
//   overrun[1:0]            : pending sample overwritten (bit0 red, bit1 IR)
module fir_mac_scheduler
    import fir_pkg::*;
(
    input  logic          CLK_Filter,
    input  logic          rst_n,
    input  logic          red_valid,
    input  logic [DW-1:0] red_sample,
    input  logic          ir_valid,
    input  logic [DW-1:0] ir_sample,
    output logic [AW-1:0] out_data,
    output logic          out_valid,
    output logic          out_ch,
    output logic          busy,
    output logic [1:0]    overrun
);

    state_t state, state_nxt;

    logic [1:0]                      vld, pend, gnt_vec;
    logic [1:0][DW-1:0]              smp, pend_val;
    logic [1:0][NTAPS-1:0][DW-1:0]   hist;
    logic                            grant, gch, ch, last_ch, last_tap;
    logic [DW-1:0]                   cur;
    logic [TW-1:0]                   tap;
    logic [CW-1:0]                   coef;
    logic [CW+DW-1:0]                prod;
    logic [AW-1:0]                   acc, acc_sum;

    assign vld = {ir_valid, red_valid};
    assign smp = {ir_sample, red_sample};

    // Both pending: the channel not served last wins; otherwise the lone requester.
    assign gch      = pend[CH_IR] & (~pend[CH_RED] | ~last_ch);
    assign gnt_vec  = grant ? (gch ? 2'b10 : 2'b01) : 2'b00;
    assign last_tap = (tap == TW'(NTAPS - 1));
    assign busy     = (state != IDLE);

    fir_coef_rom u_rom (
        .tap  (tap),
        .coef (coef)
    );

    assign prod    = coef * hist[ch][tap];
    assign acc_sum = acc + AW'(prod);

    always_ff @(posedge CLK_Filter or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: if (|pend) begin
                grant     = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT:   state_nxt = MAC;
            MAC:     if (last_tap) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture. The sample is copied out at grant, so a strobe landing on the
    // grant cycle simply re-arms pend without counting as an overrun.
    always_ff @(posedge CLK_Filter or posedge rst_n) begin
        if (rst_n) begin
            pend     <= '0;
            pend_val <= '0;
            overrun  <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (vld[c]) begin
                    pend[c]     <= 1'b1;
                    pend_val[c] <= smp[c];
                end else if (gnt_vec[c]) begin
                    pend[c] <= 1'b0;
                end
            end
            overrun <= vld & pend & ~gnt_vec;
        end
    end

    // Datapath. out_* load on the final MAC edge so out_valid is high exactly
    // during DONE, keeping grant-to-valid at NTAPS+2 cycles.
    always_ff @(posedge CLK_Filter or posedge rst_n) begin
        if (rst_n) begin
            ch        <= CH_RED;
            last_ch   <= CH_IR;
            cur       <= '0;
            hist      <= '0;
            acc       <= '0;
            tap       <= '0;
            out_data  <= '0;
            out_ch    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (grant) begin
                ch      <= gch;
                last_ch <= gch;
                cur     <= pend_val[gch];
            end
            case (state)
                SHIFT: begin
                    hist[ch] <= {hist[ch][NTAPS-2:0], cur};
                    acc      <= '0;
                    tap      <= '0;
                end
                MAC: begin
                    acc <= acc_sum;
                    tap <= tap + 1'b1;
                    if (last_tap) begin
                        out_data  <= acc_sum;
                        out_ch    <= ch;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
module tb_fir_mac_scheduler;

    logic        clk;
    logic        rst_n;
    logic        red_valid, ir_valid;
    logic [7:0]  red_sample, ir_sample;
    logic [19:0] out_data;
    logic        out_valid, out_ch, busy;
    logic [1:0]  overrun;

    fir_mac_scheduler dut (
        .CLK_Filter (clk),
        .rst_n      (rst_n),
        .red_valid  (red_valid),
        .red_sample (red_sample),
        .ir_valid   (ir_valid),
        .ir_sample  (ir_sample),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ch;
        logic [19:0] data;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   vecs = 0;
    int   errs = 0;
    int   mh[2][22];
    int   htab[11] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
    int   n_out[2];
    int   ov_cnt[2];
    logic [19:0] last_data;
    logic        last_och;

    function automatic int coef_tb(input int k);
        return (k < 11) ? htab[k] : htab[21 - k];
    endfunction

    function automatic void reset_model();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 22; k++) mh[c][k] = 0;
        q.delete();
    endfunction

    // Sample enters the channel's history; push the filter output it produces.
    function automatic void model_push(input int c, input int v);
        int   s;
        exp_t e;
        for (int k = 21; k > 0; k--) mh[c][k] = mh[c][k-1];
        mh[c][0] = v;
        s = 0;
        for (int k = 0; k < 22; k++) s += coef_tb(k) * mh[c][k];
        e.ch   = c[0];
        e.data = s[19:0];
        q.push_back(e);
    endfunction

    // Scoreboard: every out_valid pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_cnt[0] += int'(overrun[0]);
            ov_cnt[1] += int'(overrun[1]);
            if (out_valid) begin
                last_data = out_data;
                last_och  = out_ch;
                n_out[out_ch]++;
                vecs++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_out: got ch=%0d data=%0d, required no output", out_ch, out_data);
                end else begin
                    mon_e = q.pop_front();
                    if (out_ch !== mon_e.ch || out_data !== mon_e.data) begin
                        errs++;
                        $display("FAIL scoreboard: got ch=%0d data=%0d, required ch=%0d data=%0d",
                                 out_ch, out_data, mon_e.ch, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic send(input int c, input int v, input bit push);
        if (c == 0) begin red_valid = 1'b1; red_sample = v[7:0]; end
        else        begin ir_valid  = 1'b1; ir_sample  = v[7:0]; end
        if (push) model_push(c, v);
        @(negedge clk);
        red_valid = 1'b0;
        ir_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (n >= 300) begin
            errs++;
            $display("FAIL %s_timeout: got %0d results outstanding after %0d cycles, required 0", tag, q.size(), n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        red_valid = 1'b0; ir_valid = 1'b0; red_sample = '0; ir_sample = '0;
        reset_model();
        repeat (3) @(negedge clk);
        vecs++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 2'b00 || out_ch !== 1'b0 || out_data !== 20'd0) begin
            errs++;
            $display("FAIL reset_outputs: got valid=%b busy=%b ovr=%b ch=%b data=%0d, required all 0",
                     out_valid, busy, overrun, out_ch, out_data);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_release: got busy=%b valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_impulse();
        int exp_first, exp_mid, exp_last;
        exp_first = 510; exp_mid = 32640; exp_last = 510;
        for (int i = 0; i < 22; i++) begin
            send(0, (i == 0) ? 255 : 0, 1'b1);
            wait_idle("impulse");
            if (i == 0 || i == 10 || i == 21) begin
                vecs++;
                if (last_data !== 20'((i == 0) ? exp_first : (i == 10) ? exp_mid : exp_last)) begin
                    errs++;
                    $display("FAIL impulse_tap%0d: got %0d, required %0d", i, last_data,
                             (i == 0) ? exp_first : (i == 10) ? exp_mid : exp_last);
                end
            end
        end
        vecs++;
        if (n_out[1] !== 0) begin
            errs++;
            $display("FAIL impulse_ir_quiet: got %0d IR outputs, required 0", n_out[1]);
        end
    endtask

    task automatic test_step();
        for (int i = 0; i < 22; i++) begin
            send(0, 100, 1'b1);
            wait_idle("step");
        end
        vecs++;
        if (last_data !== 20'd138600) begin
            errs++;
            $display("FAIL step_final: got %0d, required 138600", last_data);
        end
        send(1, 1, 1'b1);
        wait_idle("step_ir");
        vecs++;
        if (last_data !== 20'd2 || last_och !== 1'b1) begin
            errs++;
            $display("FAIL step_ir_isolated: got ch=%0d data=%0d, required ch=1 data=2", last_och, last_data);
        end
    endtask

    task automatic test_tie();
        int t0 = -1, t1 = -1;
        red_valid = 1'b1; red_sample = 8'd7;
        ir_valid  = 1'b1; ir_sample  = 8'd9;
        model_push(0, 7);
        model_push(1, 9);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin red_valid = 1'b0; ir_valid = 1'b0; end
            if (k == 2) begin
                vecs++;
                if (busy !== 1'b1) begin
                    errs++;
                    $display("FAIL tie_busy: got %b, required 1", busy);
                end
            end
            if (out_valid === 1'b1 && out_ch === 1'b0 && t0 < 0) t0 = k;
            if (out_valid === 1'b1 && out_ch === 1'b1 && t1 < 0) t1 = k;
        end
        vecs++;
        if (t0 != 25 || t1 != 50) begin
            errs++;
            $display("FAIL tie_timing: got red@%0d ir@%0d, required red@25 ir@50", t0, t1);
        end
        wait_idle("tie");
    endtask

    task automatic test_full_scale();
        bit stable = 1'b1;
        for (int i = 0; i < 22; i++) begin
            send(0, 255, 1'b1);
            wait_idle("full");
        end
        vecs++;
        if (last_data !== 20'd353430) begin
            errs++;
            $display("FAIL full_scale: got %0d, required 353430", last_data);
        end
        repeat (30) begin
            @(negedge clk);
            if (out_data !== 20'd353430 || out_valid !== 1'b0) stable = 1'b0;
        end
        vecs++;
        if (!stable) begin
            errs++;
            $display("FAIL full_hold: got data=%0d valid=%b, required 353430 held", out_data, out_valid);
        end
    endtask

    task automatic test_overrun();
        int o0, o1;
        o0 = ov_cnt[0]; o1 = ov_cnt[1];
        send(0, 10, 1'b1);
        repeat (3) @(negedge clk);
        send(0, 20, 1'b0);
        send(0, 30, 1'b1);
        wait_idle("overrun");
        vecs++;
        if (ov_cnt[0] - o0 != 1 || ov_cnt[1] - o1 != 0) begin
            errs++;
            $display("FAIL overrun_pulses: got red=%0d ir=%0d, required red=1 ir=0",
                     ov_cnt[0] - o0, ov_cnt[1] - o1);
        end
    endtask

    task automatic test_reset_mid();
        send(0, 200, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        #1;
        vecs++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 2'b00) begin
            errs++;
            $display("FAIL reset_mid_abort: got busy=%b valid=%b ovr=%b, required 0 0 00", busy, out_valid, overrun);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        send(0, 255, 1'b1);
        wait_idle("reset_mid");
        vecs++;
        if (last_data !== 20'd510) begin
            errs++;
            $display("FAIL reset_mid_restart: got %0d, required 510", last_data);
        end
    endtask

    initial begin
        n_out[0] = 0; n_out[1] = 0;
        ov_cnt[0] = 0; ov_cnt[1] = 0;
        last_data = '0; last_och = 1'b0;
        test_reset();
        test_impulse();
        test_step();
        test_tie();
        test_full_scale();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
